// File: rtl/rxbar_unit.sv
// Read-return crossbar: gathers each output lane of a returned SRAM row from a
// selected bank column, zeroes inactive lanes, and delivers the permuted row
// with its metadata through a delay pipeline and a 2-entry response FIFO.
module rxbar_unit #(
  parameter int NUM_COLS     = 32,
  parameter int ELEM_BITS    = 16,
  parameter int SEL_BITS     = $clog2(NUM_COLS),
  parameter int SRC_BITS     = 2,
  parameter int XBAR_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_COLS*ELEM_BITS-1:0] in_data,
  input  logic [NUM_COLS*SEL_BITS-1:0]  in_sel,
  input  logic [NUM_COLS-1:0]           in_valid_mask,
  input  logic [SRC_BITS-1:0]           in_src,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [NUM_COLS*ELEM_BITS-1:0] resp_data,
  output logic [NUM_COLS-1:0]           resp_valid_mask,
  output logic [SRC_BITS-1:0]           resp_src,
  output logic                          busy
);

  localparam int NUM_STAGES = XBAR_LATENCY - 1;

  // One gathered row plus the metadata that must travel in lockstep with it.
  typedef struct packed {
    logic [NUM_COLS*ELEM_BITS-1:0] data;
    logic [NUM_COLS-1:0]           mask;
    logic [SRC_BITS-1:0]           src;
  } row_t;

  row_t gath_row;
  row_t last_row;
  logic last_valid;
  logic stg_any;
  logic advance;
  logic push;
  logic pop;
  logic fifo_full;

  row_t       fifo_mem [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;

  // Combinational gather: each active lane picks the column its select names.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    gath_row.data = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (in_valid_mask[i]) begin
        gath_row.data[i*ELEM_BITS +: ELEM_BITS] =
          in_data[int'(in_sel[i*SEL_BITS +: SEL_BITS])*ELEM_BITS +: ELEM_BITS];
      end
    end
    gath_row.mask = in_valid_mask;
    gath_row.src  = in_src;
  end

  generate
    if (NUM_STAGES == 0) begin : g_direct
      // With a single cycle of latency the gathered row feeds the FIFO directly.
      assign last_valid = in_valid;
      assign last_row   = gath_row;
      assign stg_any    = 1'b0;
    end else begin : g_stages
      logic [NUM_STAGES-1:0] vld_q;
      row_t                  row_q [NUM_STAGES];

      // Stage valid bits shift together on advance; bubbles are kept as-is.
      always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every stage
        // samples the previous stage's old value at the same edge.
        if (rst) begin
          vld_q <= '0;
        end else if (clr) begin
          vld_q <= '0;
        end else if (advance) begin
          vld_q[0] <= in_valid;
          for (int j = 1; j < NUM_STAGES; j++) begin
            vld_q[j] <= vld_q[j-1];
          end
        end
      end

      // Stage payloads shift alongside their valid bits.
      always_ff @(posedge clk) begin
        // NOTE: payload storage carries no reset; the valid bits alone decide
        // whether its contents mean anything, so reset only the valids.
        if (advance) begin
          row_q[0] <= gath_row;
          for (int j = 1; j < NUM_STAGES; j++) begin
            row_q[j] <= row_q[j-1];
          end
        end
      end

      assign last_valid = vld_q[NUM_STAGES-1];
      assign last_row   = row_q[NUM_STAGES-1];
      assign stg_any    = |vld_q;
    end
  endgenerate

  assign resp_valid = (cnt_q != 2'd0);
  assign fifo_full  = (cnt_q == 2'd2);
  assign pop        = resp_valid && resp_ready;
  assign advance    = !last_valid || !fifo_full || pop;
  assign push       = advance && last_valid;
  assign in_ready   = advance;

  // FIFO pointer and occupancy next-state; full-with-push always implies pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO control registers; flush empties the buffer and rewinds pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (clr) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage written at the tail; the head entry is never overwritten
  // while it is being presented.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= last_row;
    end
  end

  // Head of the FIFO drives the response, forced to zero when nothing is valid.
  always_comb begin
    resp_data       = '0;
    resp_valid_mask = '0;
    resp_src        = '0;
    if (resp_valid) begin
      resp_data       = fifo_mem[rd_ptr_q].data;
      resp_valid_mask = fifo_mem[rd_ptr_q].mask;
      resp_src        = fifo_mem[rd_ptr_q].src;
    end
  end

  assign busy = stg_any || resp_valid;

endmodule

// File: tb/tb_rxbar_unit.sv
// Bench for rxbar_unit: directed scenarios plus random traffic, checked against
// a transaction-level model (a queue of expected rows, with capacity rules).
module tb_rxbar_unit;

  localparam int NC   = 32;
  localparam int EB   = 16;
  localparam int SB   = 5;
  localparam int SRCB = 2;
  localparam int LAT  = 2;
  localparam int DW   = NC * EB;
  localparam int CAP  = LAT + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            clr;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [NC*SB-1:0] in_sel;
  logic [NC-1:0]   in_valid_mask;
  logic [SRCB-1:0] in_src;
  logic            resp_valid;
  logic            resp_ready;
  logic [DW-1:0]   resp_data;
  logic [NC-1:0]   resp_valid_mask;
  logic [SRCB-1:0] resp_src;
  logic            busy;

  always #5 clk = ~clk;

  rxbar_unit #(
    .NUM_COLS(NC), .ELEM_BITS(EB), .SEL_BITS(SB), .SRC_BITS(SRCB), .XBAR_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .in_valid_mask(in_valid_mask), .in_src(in_src),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_valid_mask(resp_valid_mask), .resp_src(resp_src), .busy(busy)
  );

  typedef struct {
    logic [DW-1:0]   data;
    logic [NC-1:0]   mask;
    logic [SRCB-1:0] src;
  } exp_row_t;

  exp_row_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  n_pop = 0;
  bit  last_acc = 0;
  bit  prev_stall = 0;
  int  max_q = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference gather written lane by lane from the column table.
  function automatic logic [DW-1:0] gather(input logic [DW-1:0] d, input logic [NC*SB-1:0] s,
                                           input logic [NC-1:0] m);
    logic [EB-1:0] col [NC];
    logic [DW-1:0] res;
    for (int c = 0; c < NC; c++) col[c] = d[c*EB +: EB];
    res = '0;
    for (int i = 0; i < NC; i++) begin
      if (m[i]) res[i*EB +: EB] = col[s[i*SB +: SB]];
    end
    return res;
  endfunction

  // One clock: check outputs against the model, then update it at the edge.
  task automatic step();
    bit acc, pp;
    exp_row_t nr;
    #1;
    check("in_ready", in_ready, (exp_q.size() == CAP && !resp_ready) ? 1'b0 : 1'b1);
    check("busy", busy, exp_q.size() != 0);
    if (prev_stall) check("hold_valid", resp_valid, 1'b1);
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        check("stale_resp", resp_valid, 1'b0);
      end else begin
        check("resp_data", resp_data, exp_q[0].data);
        check("resp_mask", resp_valid_mask, exp_q[0].mask);
        check("resp_src", resp_src, exp_q[0].src);
      end
    end
    acc = in_valid && in_ready;
    pp  = resp_valid && resp_ready && exp_q.size() != 0;
    prev_stall = resp_valid && !resp_ready;
    nr.data = gather(in_data, in_sel, in_valid_mask);
    nr.mask = in_valid_mask;
    nr.src  = in_src;
    @(posedge clk);
    last_acc = 0;
    if (clr) begin
      exp_q.delete();
      prev_stall = 0;
    end else begin
      if (pp) begin
        void'(exp_q.pop_front());
        n_pop++;
      end
      if (acc) begin
        exp_q.push_back(nr);
        last_acc = 1;
      end
    end
    if (exp_q.size() > max_q) max_q = exp_q.size();
    @(negedge clk);
  endtask

  task automatic rand_row();
    for (int w = 0; w < DW/32; w++) in_data[w*32 +: 32] = $urandom;
    for (int i = 0; i < NC; i++) in_sel[i*SB +: SB] = SB'($urandom_range(0, NC-1));
    in_valid_mask = $urandom;
    if ($urandom_range(0, 7) == 0) in_valid_mask = '0;
    in_src = SRCB'($urandom_range(0, 3));
  endtask

  task automatic ident_data();
    for (int c = 0; c < NC; c++) in_data[c*EB +: EB] = EB'(16'h100 + c);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0]   exp_v;
    logic [DW-1:0]   bp_data [5];
    logic [SRCB-1:0] bp_src  [5];
    int idx, acc_cnt, pops0, k;

    rst = 1; clr = 0; in_valid = 0; resp_ready = 0;
    in_data = '0; in_sel = '0; in_valid_mask = '0; in_src = '0;
    #12;
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_data", resp_data, '0);
    check("rst_resp_mask", resp_valid_mask, '0);
    check("rst_resp_src", resp_src, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    // Identity mapping and latency.
    ident_data();
    for (int i = 0; i < NC; i++) in_sel[i*SB +: SB] = SB'(i);
    in_valid_mask = '1; in_src = 2'd1; in_valid = 1; resp_ready = 1;
    step();
    in_valid = 0;
    #1 check("ident_early", resp_valid, 1'b0);
    step();
    for (int c = 0; c < NC; c++) exp_v[c*EB +: EB] = EB'(16'h100 + c);
    #1 check("ident_valid", resp_valid, 1'b1);
    check("ident_data", resp_data, exp_v);
    check("ident_src", resp_src, 2'd1);
    step();

    // Rotate by 3.
    for (int i = 0; i < NC; i++) in_sel[i*SB +: SB] = SB'((i + 3) % NC);
    in_valid = 1;
    step();
    in_valid = 0;
    step();
    for (int i = 0; i < NC; i++) exp_v[i*EB +: EB] = EB'(16'h100 + (i + 3) % NC);
    #1 check("rot_data", resp_data, exp_v);
    step();

    // Broadcast column 5 to the lower half, upper half masked.
    for (int i = 0; i < NC; i++) in_sel[i*SB +: SB] = 5'd5;
    in_valid_mask = 32'h0000_FFFF; in_valid = 1;
    step();
    in_valid = 0;
    step();
    exp_v = '0;
    for (int i = 0; i < 16; i++) exp_v[i*EB +: EB] = 16'h105;
    #1 check("bcast_data", resp_data, exp_v);
    check("bcast_mask", resp_valid_mask, 32'h0000_FFFF);
    step();
    step();

    // Backpressure: five rows offered, only three fit while stalled.
    for (int r = 0; r < 5; r++) begin
      rand_row();
      bp_data[r] = in_data;
      bp_src[r]  = SRCB'(r % 4);
    end
    resp_ready = 0; idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1; in_data = bp_data[idx]; in_src = bp_src[idx];
      step();
      if (last_acc) idx++;
    end
    check("bp_accepted", idx, 3);
    #1 check("bp_in_ready", in_ready, 1'b0);
    check("bp_busy", busy, 1'b1);
    resp_ready = 1; pops0 = n_pop; k = 0;
    while ((idx < 5 || exp_q.size() != 0) && k < 30) begin
      if (idx < 5) begin
        in_valid = 1; in_data = bp_data[idx]; in_src = bp_src[idx];
      end else begin
        in_valid = 0;
      end
      step();
      if (last_acc) idx++;
      k++;
    end
    check("bp_all_out", n_pop - pops0, 5);

    // Sustained throughput with the consumer always ready.
    in_valid = 1; resp_ready = 1; acc_cnt = 0; max_q = 0;
    for (int c = 0; c < 40; c++) begin
      rand_row();
      step();
      if (last_acc) acc_cnt++;
    end
    check("thru_accepts", acc_cnt, 40);
    check("thru_bound", max_q <= CAP, 1'b1);
    in_valid = 0;
    for (int c = 0; c < 6; c++) step();

    // Flush with three rows in flight.
    resp_ready = 0; in_valid = 1;
    for (int c = 0; c < 3; c++) begin
      rand_row();
      step();
    end
    clr = 1;
    step();
    clr = 0; in_valid = 0;
    #1 check("clr_resp_valid", resp_valid, 1'b0);
    check("clr_busy", busy, 1'b0);
    check("clr_in_ready", in_ready, 1'b1);
    ident_data();
    for (int i = 0; i < NC; i++) in_sel[i*SB +: SB] = SB'(NC - 1 - i);
    in_valid_mask = '1; in_src = 2'd2; in_valid = 1; resp_ready = 1;
    step();
    in_valid = 0;
    step();
    for (int i = 0; i < NC; i++) exp_v[i*EB +: EB] = EB'(16'h100 + NC - 1 - i);
    #1 check("clr_new_valid", resp_valid, 1'b1);
    check("clr_new_data", resp_data, exp_v);
    step();

    // Asynchronous reset with the FIFO full.
    resp_ready = 0; in_valid = 1;
    for (int c = 0; c < 4; c++) begin
      rand_row();
      step();
    end
    in_valid = 0;
    #2 rst = 1;
    #1;
    check("arst_resp_valid", resp_valid, 1'b0);
    check("arst_resp_data", resp_data, '0);
    check("arst_busy", busy, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    prev_stall = 0;
    @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    resp_ready = 1;
    for (int c = 0; c < 5; c++) step();

    // Random traffic with occasional flushes.
    for (int c = 0; c < 3000; c++) begin
      rand_row();
      in_valid   = ($urandom_range(0, 3) != 0);
      resp_ready = ($urandom_range(0, 2) != 0);
      clr        = ($urandom_range(0, 63) == 0);
      step();
    end
    clr = 0; in_valid = 0; resp_ready = 1;
    for (int c = 0; c < 10; c++) step();
    check("drain_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
